// File: rtl/spi_reg_bank_ctrl_if.sv
// Byte-level link between the SPI slave shift stage and the register-bank controller.
// Both sides run on sclk. The slave drives the rx side, and the controller drives the tx/bank side.
interface spi_reg_bank_ctrl_if #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic                  slave_select;
  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic [7:0]            tx_byte;
  logic [NUM_REGS*8-1:0] reg_flat;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  frame_err;
  logic [7:0]            byte_cnt;

  modport master (
    output slave_select, rx_byte, rx_valid,
    input  tx_byte, reg_flat, wr_strobe, wr_addr, frame_err, byte_cnt
  );

  modport slave (
    input  slave_select, rx_byte, rx_valid,
    output tx_byte, reg_flat, wr_strobe, wr_addr, frame_err, byte_cnt
  );
endinterface

// File: rtl/spi_reg_bank_ctrl.sv
// SPI command/data frame decoder and register bank. A write reaches tx_byte in 2 cycles. There is no backpressure: each rx_valid byte is consumed.
// Optional SPI_REG_WRITE_PROTECT_EN: reg[0] bit0 locks writes to every address except 0.
module spi_reg_bank_ctrl #(
  parameter int         NUM_REGS  = 8,
  parameter int         ADDR_W    = 3,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic               sclk,
  input  logic               reset,
  spi_reg_bank_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, DRAIN} state_t;

  state_t                     state;
  logic [NUM_REGS-1:0][7:0]   regs;
  logic [ADDR_W-1:0]          rd_addr;
  logic [ADDR_W-1:0]          addr_ptr;
  logic                       ss_q;
  logic [7:0]                 tx_byte;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;
  logic [7:0]                 byte_cnt;

  logic                       addr_bad;
  logic [ADDR_W-1:0]          cmd_addr;
  logic [ADDR_W-1:0]          ptr_next;
  logic [7:0]                 cnt_next;
  logic                       wr_lock;

  always_comb begin
    addr_bad = {1'b0, bus.rx_byte[6:0]} >= 8'(NUM_REGS);
    cmd_addr = bus.rx_byte[ADDR_W-1:0];
    ptr_next = (addr_ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_ptr + 1'b1;
    cnt_next = (byte_cnt == 8'hFF) ? 8'hFF : byte_cnt + 8'd1;
`ifdef SPI_REG_WRITE_PROTECT_EN
    wr_lock  = regs[0][0] && (addr_ptr != '0);
`else
    wr_lock  = 1'b0;
`endif
  end

  // A new frame starts only on a 1->0 slave_select edge. After a mid-frame reset, a held-low select stays idle.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state     <= IDLE;
      regs      <= {NUM_REGS{RESET_VAL}};
      tx_byte   <= RESET_VAL;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      byte_cnt  <= 8'd0;
      rd_addr   <= '0;
      addr_ptr  <= '0;
      ss_q      <= 1'b0;
    end else begin
      ss_q      <= bus.slave_select;
      wr_strobe <= 1'b0;
      tx_byte   <= regs[rd_addr];
      case (state)
        IDLE: begin
          if (!bus.slave_select && ss_q) begin
            state    <= CMD;
            byte_cnt <= 8'd0;
          end
        end
        CMD: begin
          if (bus.rx_valid) begin
            byte_cnt <= cnt_next;
            if (addr_bad) begin
              frame_err <= 1'b1;
              state     <= DRAIN;
            end else if (bus.rx_byte[7]) begin
              rd_addr <= cmd_addr;
              state   <= DRAIN;
            end else begin
              addr_ptr <= cmd_addr;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (bus.rx_valid) begin
            byte_cnt <= cnt_next;
            if (wr_lock) begin
              frame_err <= 1'b1;
              state     <= DRAIN;
            end else begin
              regs[addr_ptr] <= bus.rx_byte;
              wr_strobe      <= 1'b1;
              wr_addr        <= addr_ptr;
              addr_ptr       <= ptr_next;
            end
          end
        end
        DRAIN: begin
          if (bus.rx_valid) byte_cnt <= cnt_next;
        end
        default: state <= IDLE;
      endcase
      // A byte arriving with the deselect edge has already been handled above.
      if (bus.slave_select && state != IDLE) state <= IDLE;
    end
  end

  assign bus.tx_byte   = tx_byte;
  assign bus.reg_flat  = regs;
  assign bus.wr_strobe = wr_strobe;
  assign bus.wr_addr   = wr_addr;
  assign bus.frame_err = frame_err;
  assign bus.byte_cnt  = byte_cnt;

endmodule

// File: tb/tb_spi_reg_bank_ctrl.sv
// Directed and random frames against a frame-level reference model of the register bank.
module tb_spi_reg_bank_ctrl;
  localparam int NR = 8;
  localparam int AW = 3;

  logic sclk  = 1'b0;
  logic reset = 1'b1;
  always #5 sclk = ~sclk;

  spi_reg_bank_ctrl_if #(.NUM_REGS(NR), .ADDR_W(AW)) bus ();

  spi_reg_bank_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(8'h00)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mregs [NR];
  logic       merr;
  int         mrd;
  int         mwaddr;
  int         mcnt;
  logic [7:0] fq [$];
  int         exp_stb [$];
  int         obs_stb [$];

  always @(negedge sclk) if (bus.wr_strobe) obs_stb.push_back(int'(bus.wr_addr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = mregs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    merr = 1'b0; mrd = 0; mwaddr = 0; mcnt = 0;
  endtask

  // Whole-frame effect: the first byte is the command, and the remaining bytes are data.
  task automatic model_frame();
    int addr, p;
    exp_stb.delete();
    mcnt = (fq.size() > 255) ? 255 : fq.size();
    addr = int'(fq[0][6:0]);
    if (addr >= NR) merr = 1'b1;
    else if (fq[0][7]) mrd = addr;
    else begin
      p = addr;
      for (int i = 1; i < fq.size(); i++) begin
`ifdef SPI_REG_WRITE_PROTECT_EN
        if (mregs[0][0] && p != 0) begin
          merr = 1'b1;
          break;
        end
`endif
        mregs[p] = fq[i];
        exp_stb.push_back(p);
        mwaddr = p;
        p = (p + 1) % NR;
      end
    end
  endtask

  task automatic drive_frame(input bit coincide);
    obs_stb.delete();
    @(negedge sclk); bus.slave_select = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge sclk);
      bus.rx_byte  = fq[i];
      bus.rx_valid = 1'b1;
      if (coincide && i == fq.size() - 1) bus.slave_select = 1'b1;
      if (i != fq.size() - 1 && $urandom_range(0, 3) == 0) begin
        @(negedge sclk); bus.rx_valid = 1'b0;
      end
    end
    @(negedge sclk); bus.rx_valid = 1'b0; bus.slave_select = 1'b1;
    cyc(3);
  endtask

  task automatic check_all(input string tag);
    int n;
    chk({tag, ".regs"}, bus.reg_flat, model_flat());
    chk({tag, ".err"}, 64'(bus.frame_err), 64'(merr));
    chk({tag, ".cnt"}, 64'(bus.byte_cnt), 64'(mcnt));
    chk({tag, ".waddr"}, 64'(bus.wr_addr), 64'(mwaddr));
    chk({tag, ".tx"}, 64'(bus.tx_byte), 64'(mregs[mrd]));
    chk({tag, ".nstb"}, 64'(obs_stb.size()), 64'(exp_stb.size()));
    n = (obs_stb.size() < exp_stb.size()) ? obs_stb.size() : exp_stb.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.stb%0d", tag, i), 64'(obs_stb[i]), 64'(exp_stb[i]));
  endtask

  task automatic run(input string tag, input bit coincide);
    model_frame();
    drive_frame(coincide);
    check_all(tag);
  endtask

  initial begin
    bus.slave_select = 1'b1;
    bus.rx_byte      = 8'h00;
    bus.rx_valid     = 1'b0;
    model_reset();
    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("rst.regs", bus.reg_flat, 64'h0);
    chk("rst.tx", 64'(bus.tx_byte), 64'h0);
    chk("rst.err", 64'(bus.frame_err), 64'h0);
    chk("rst.cnt", 64'(bus.byte_cnt), 64'h0);
    chk("rst.stb", 64'(bus.wr_strobe), 64'h0);

    fq = '{8'h02, 8'hA5, 8'h3C};                 run("wr2", 1'b0);
    fq = '{8'h07, 8'h11, 8'h22, 8'h33};          run("wrap", 1'b0);
    fq = '{8'h82};                               run("rd2", 1'b0);
    chk("rd2.tx_a5", 64'(bus.tx_byte), 64'hA5);
    fq = '{8'h82, 8'h01, 8'h02};                 run("rd2b", 1'b0);
    fq = '{8'h0A, 8'hFF};                        run("badaddr", 1'b0);
    chk("badaddr.err1", 64'(bus.frame_err), 64'h1);
    fq = '{8'h01, 8'h55};                        run("coinc", 1'b1);
    chk("coinc.r1", 64'(bus.reg_flat[15:8]), 64'h55);

    // Reset in the middle of a frame, with slave_select still held low afterwards.
    @(negedge sclk); bus.slave_select = 1'b0;
    @(negedge sclk); bus.rx_byte = 8'h01; bus.rx_valid = 1'b1;
    @(negedge sclk); bus.rx_byte = 8'h66;
    @(negedge sclk); bus.rx_valid = 1'b0; reset = 1'b1;
    @(negedge sclk); reset = 1'b0;
    model_reset();
    exp_stb.delete();
    chk("midrst.regs", bus.reg_flat, 64'h0);
    chk("midrst.tx", 64'(bus.tx_byte), 64'h0);
    chk("midrst.err", 64'(bus.frame_err), 64'h0);
    obs_stb.delete();
    @(negedge sclk); bus.rx_byte = 8'h01; bus.rx_valid = 1'b1;
    @(negedge sclk); bus.rx_byte = 8'h77;
    @(negedge sclk); bus.rx_valid = 1'b0;
    cyc(2);
    check_all("heldlow");
    @(negedge sclk); bus.slave_select = 1'b1;
    cyc(2);

    fq = '{8'h80};
    for (int i = 0; i < 259; i++) fq.push_back(8'($urandom));
    run("sat", 1'b0);
    chk("sat.cnt255", 64'(bus.byte_cnt), 64'd255);

`ifdef SPI_REG_WRITE_PROTECT_EN
    fq = '{8'h00, 8'h01};                        run("lock", 1'b0);
    fq = '{8'h03, 8'h77};                        run("locked", 1'b0);
    chk("locked.err1", 64'(bus.frame_err), 64'h1);
    fq = '{8'h00, 8'h00};                        run("unlock", 1'b0);
    fq = '{8'h03, 8'h77};                        run("retry", 1'b0);
    chk("retry.r3", 64'(bus.reg_flat[31:24]), 64'h77);
`endif

    for (int f = 0; f < 40; f++) begin
      int n;
      fq.delete();
      fq.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, NR + 1))});
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
      run($sformatf("rnd%0d", f), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
